// File: rtl/uart_pkg.sv
// Shared types and constants for the flow-controlled UART transmitter.
// Holds the FSM encoding, parity senses, timing floor and data-length bounds.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } tx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int MIN_DIV = 4;

    localparam logic [3:0] DLEN_MIN = 4'd5;
    localparam logic [3:0] DLEN_MAX = 4'd8;

    // Out-of-range lengths fall back to a full byte.
    function automatic logic [3:0] eff_len(input logic [3:0] l);
        if (l < DLEN_MIN || l > DLEN_MAX)
            return DLEN_MAX;
        return l;
    endfunction

    function automatic logic par_bit(
        input logic [7:0] d,
        input logic [3:0] len,
        input logic       sense
    );
        logic [7:0] m;
        m = 8'hFF >> (DLEN_MAX - len);
        return (^(d & m)) ^ (sense == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with occupancy count and a dropped-write pulse.
// Full is taken from the registered count, so a write while full is lost.
import uart_pkg::*;

module uart_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     rd,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   cnt,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      cnt_q;
    logic             ovf_q;
    logic             wr_ok;
    logic             rd_ok;

    assign full  = (cnt_q == (AW+1)'(DEPTH));
    assign empty = (cnt_q == '0);
    assign wr_ok = wr && !full;
    assign rd_ok = rd && !empty;

    assign rdata    = mem[rptr];
    assign cnt      = cnt_q;
    assign overflow = ovf_q;

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= wr && full;
            if (wr_ok)
                wptr <= wptr + 1'b1;
            if (rd_ok)
                rptr <= rptr + 1'b1;
            unique case ({wr_ok, rd_ok})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fc.sv
// UART transmitter with TX FIFO, CTS flow control and break generation.
// tx and tx_work are registered from the current FSM state.
import uart_pkg::*;

module uart_tx_fc #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 20
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DIV_W-1:0]              baud_div,
    input  logic [3:0]                    data_length,
    input  logic                          check,
    input  logic                          parity,
    input  logic                          stop2,
    input  logic                          cts_n,
    input  logic                          brk,
    input  logic [7:0]                    tx_in_data,
    input  logic                          tx_fifo_write,
    output logic [$clog2(FIFO_DEPTH):0]   tx_fifo_cnt,
    output logic                          tx_fifo_full,
    output logic                          tx_fifo_empty,
    output logic                          tx_overflow,
    output logic                          tx_work,
    output logic                          tx
);

    tx_state_e        state, state_n;
    logic [DIV_W-1:0] tmr, tmr_n;
    logic [DIV_W-1:0] div, div_n;
    logic [DIV_W-1:0] div_eff;
    logic [3:0]       idx, idx_n;
    logic [3:0]       len, len_n;
    logic [7:0]       sh, sh_n;
    logic             chk, chk_n;
    logic             pbit, pbit_n;
    logic             st2, st2_n;
    logic             mark, mark_n;
    logic             tx_n;
    logic             pop;
    logic             load;
    logic             launch;
    logic             bit_end;
    logic             cts_s1, cts_s2;
    logic [7:0]       rdata;

    uart_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr       (tx_fifo_write),
        .wdata    (tx_in_data),
        .rd       (pop),
        .rdata    (rdata),
        .cnt      (tx_fifo_cnt),
        .full     (tx_fifo_full),
        .empty    (tx_fifo_empty),
        .overflow (tx_overflow)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cts_s1 <= 1'b1;
            cts_s2 <= 1'b1;
        end else begin
            cts_s1 <= cts_n;
            cts_s2 <= cts_s1;
        end
    end

    assign div_eff = (baud_div < DIV_W'(MIN_DIV)) ?
                     DIV_W'(MIN_DIV) : baud_div;
    assign bit_end = (tmr == div - 1'b1);
    assign launch  = !brk && !tx_fifo_empty && !cts_s2;

    always_comb begin
        state_n = state;
        tmr_n   = bit_end ? '0 : tmr + 1'b1;
        div_n   = div;
        idx_n   = idx;
        len_n   = len;
        sh_n    = sh;
        chk_n   = chk;
        pbit_n  = pbit;
        st2_n   = st2;
        mark_n  = mark;
        tx_n    = 1'b1;
        load    = 1'b0;
        unique case (state)
            IDLE: begin
                tmr_n  = '0;
                idx_n  = '0;
                mark_n = 1'b0;
                if (brk) begin
                    state_n = BREAK;
                    div_n   = div_eff;
                end else if (launch) begin
                    load = 1'b1;
                end
            end
            START: begin
                tx_n = 1'b0;
                if (bit_end)
                    state_n = DATA;
            end
            DATA: begin
                tx_n = sh[0];
                if (bit_end) begin
                    sh_n  = sh >> 1;
                    idx_n = idx + 1'b1;
                    if (idx == len - 1'b1) begin
                        idx_n   = '0;
                        state_n = chk ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                tx_n = pbit;
                if (bit_end)
                    state_n = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    idx_n = idx + 1'b1;
                    if (idx == {3'b000, st2}) begin
                        if (launch)
                            load = 1'b1;
                        else
                            state_n = IDLE;
                    end
                end
            end
            BREAK: begin
                tx_n = mark;
                if (!mark) begin
                    tmr_n = '0;
                    if (!brk)
                        mark_n = 1'b1;
                end else if (bit_end) begin
                    if (launch)
                        load = 1'b1;
                    else
                        state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        // Frame setup is sampled once here and held for the whole frame.
        if (load) begin
            state_n = START;
            tmr_n   = '0;
            idx_n   = '0;
            mark_n  = 1'b0;
            sh_n    = rdata;
            len_n   = eff_len(data_length);
            chk_n   = check;
            pbit_n  = par_bit(rdata, eff_len(data_length), parity);
            st2_n   = stop2;
            div_n   = div_eff;
        end
    end

    assign pop = load;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tmr     <= '0;
            div     <= DIV_W'(MIN_DIV);
            idx     <= '0;
            len     <= DLEN_MAX;
            sh      <= '0;
            chk     <= 1'b0;
            pbit    <= 1'b0;
            st2     <= 1'b0;
            mark    <= 1'b0;
            tx      <= 1'b1;
            tx_work <= 1'b0;
        end else begin
            state   <= state_n;
            tmr     <= tmr_n;
            div     <= div_n;
            idx     <= idx_n;
            len     <= len_n;
            sh      <= sh_n;
            chk     <= chk_n;
            pbit    <= pbit_n;
            st2     <= st2_n;
            mark    <= mark_n;
            tx      <= tx_n;
            tx_work <= (state != IDLE);
        end
    end

endmodule
